uart_tx_frame_builder: RTL and testbench

Downstream consumer of the TX-side byte FIFO. Drains buffered payload bytes and wraps them in a frame for the UART TX serializer: header, payload, length, XOR checksum. A frame starts when the FIFO signals its limit level, or when data has waited too long in the FIFO.

---
 rtl/uart_frame_pkg.sv | 18 +
 rtl/uart_tx_frame_builder_if.sv | 34 +++
 rtl/uart_tx_frame_builder_idle_timer.sv | 28 ++
 rtl/uart_tx_frame_builder.sv | 155 +++++++++++++++
 tb/tb_uart_tx_frame_builder.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared types and constants for the UART TX frame builder
package uart_frame_pkg;

  typedef logic [7:0] frame_byte_t;

  localparam frame_byte_t HDR_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    FETCH,
    WAIT_DATA,
    PAYLOAD,
    LENGTH,
    CHK
  } frame_state_t;

endpackage

// File: rtl/uart_tx_frame_builder_if.sv
// rtl/uart_tx_frame_builder_if.sv - FIFO read side and UART TX byte stream of the frame builder
interface uart_tx_frame_builder_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] fifo_data_in;
  logic             fifo_empty;
  logic             fifo_reach_limit;
  logic             fifo_rd_ins;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;

  modport master (
    input  fifo_data_in,
    input  fifo_empty,
    input  fifo_reach_limit,
    output fifo_rd_ins,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    output fifo_data_in,
    output fifo_empty,
    output fifo_reach_limit,
    input  fifo_rd_ins,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/uart_tx_frame_builder_idle_timer.sv
// rtl/uart_tx_frame_builder_idle_timer.sv - saturating count of cycles data has waited unframed
module frame_idle_timer #(
  parameter int IDLE_TIMEOUT = 2000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  output logic o_expired
);

  localparam int TW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST = TW'(IDLE_TIMEOUT - 1);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (r_cnt != LAST) begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

  assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx_frame_builder.sv
// rtl/uart_tx_frame_builder.sv - drains the TX FIFO into header/payload/length/XOR-checksum frames
module uart_tx_frame_builder
  import uart_frame_pkg::*;
#(
  parameter int          WIDTH        = 8,
  parameter int          MAX_PAYLOAD  = 58,
  parameter int          IDLE_TIMEOUT = 2000,
  parameter int          RD_LATENCY   = 1,
  parameter frame_byte_t HDR_BYTE     = HDR_BYTE_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  uart_tx_frame_builder_if.master bus,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int CW = $clog2(MAX_PAYLOAD + 1);
  localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  frame_state_t     r_state;
  frame_state_t     w_next;
  logic [CW-1:0]    r_count;
  frame_byte_t      r_chk;
  logic [WIDTH-1:0] r_byte;
  logic [LW-1:0]    r_lat;

  logic        w_expired;
  logic        w_timer_clear;
  logic        w_start;
  logic        w_hs;
  logic        w_lat_done;
  logic        w_payload_full;
  logic        w_rd_ins;
  logic        w_tx_valid;
  frame_byte_t w_tx_data;

  assign busy          = (r_state != IDLE);
  assign w_timer_clear = bus.fifo_empty || busy;

  frame_idle_timer #(
    .IDLE_TIMEOUT (IDLE_TIMEOUT)
  ) u_idle_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_timer_clear),
    .o_expired (w_expired)
  );

  assign w_start        = enable && !bus.fifo_empty && (bus.fifo_reach_limit || w_expired);
  assign w_hs           = w_tx_valid && bus.tx_ready;
  assign w_lat_done     = (r_lat == LW'(RD_LATENCY - 1));
  assign w_payload_full = (r_count == CW'(MAX_PAYLOAD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // tx_valid/tx_data decode from state only; tx_ready just gates the transition
  always_comb begin
    w_next     = r_state;
    w_rd_ins   = 1'b0;
    w_tx_valid = 1'b0;
    w_tx_data  = '0;
    frame_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) w_next = HEADER;
      end
      HEADER: begin
        w_tx_valid = 1'b1;
        w_tx_data  = HDR_BYTE;
        if (w_hs) w_next = FETCH;
      end
      FETCH: begin
        if (bus.fifo_empty || w_payload_full) begin
          w_next = LENGTH;
        end else begin
          w_rd_ins = 1'b1;
          w_next   = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (w_lat_done) w_next = PAYLOAD;
      end
      PAYLOAD: begin
        w_tx_valid = 1'b1;
        w_tx_data  = r_byte;
        if (w_hs) w_next = FETCH;
      end
      LENGTH: begin
        w_tx_valid = 1'b1;
        w_tx_data  = frame_byte_t'(r_count);
        if (w_hs) w_next = CHK;
      end
      CHK: begin
        w_tx_valid = 1'b1;
        w_tx_data  = r_chk;
        if (w_hs) begin
          frame_done = 1'b1;
          w_next     = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_chk   <= '0;
      r_byte  <= '0;
      r_lat   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_count <= '0;
            r_chk   <= '0;
          end
        end
        HEADER: begin
          if (w_hs) r_chk <= r_chk ^ HDR_BYTE;
        end
        FETCH: begin
          r_lat <= '0;
        end
        WAIT_DATA: begin
          if (w_lat_done) r_byte <= bus.fifo_data_in;
          else            r_lat  <= r_lat + LW'(1);
        end
        PAYLOAD: begin
          if (w_hs) begin
            r_chk   <= r_chk ^ r_byte;
            r_count <= r_count + CW'(1);
          end
        end
        LENGTH: begin
          if (w_hs) r_chk <= r_chk ^ frame_byte_t'(r_count);
        end
        default: ;
      endcase
    end
  end

  assign bus.fifo_rd_ins = w_rd_ins;
  assign bus.tx_valid    = w_tx_valid;
  assign bus.tx_data     = w_tx_data;

endmodule

// File: tb/tb_uart_tx_frame_builder.sv
// tb/tb_uart_tx_frame_builder.sv - directed self-checking bench for uart_tx_frame_builder
module tb_uart_tx_frame_builder;

  typedef logic [7:0] bq_t[$];

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic enable = 1'b0;
  logic busy;
  logic frame_done;

  int checks = 0;
  int errors = 0;

  uart_tx_frame_builder_if #(.WIDTH(8)) bus ();

  uart_tx_frame_builder #(
    .WIDTH        (8),
    .MAX_PAYLOAD  (58),
    .IDLE_TIMEOUT (16),
    .RD_LATENCY   (1),
    .HDR_BYTE     (8'hA5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .bus        (bus.master),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // FIFO model: registered read data and flags, one cycle read latency
  logic [7:0] fifo_q[$];
  int rd_count     = 0;
  int rd_empty_err = 0;

  always @(posedge clk) begin
    if (bus.fifo_rd_ins === 1'b1) begin
      if (fifo_q.size() == 0) rd_empty_err++;
      else bus.fifo_data_in <= fifo_q.pop_front();
      rd_count++;
    end
    bus.fifo_empty       <= (fifo_q.size() == 0);
    bus.fifo_reach_limit <= (fifo_q.size() >= 58);
  end

  bq_t        rx_q;
  int         rd_per_frame[$];
  int         done_cnt     = 0;
  int         valid_cycles = 0;
  int         stab_err     = 0;
  logic       prev_stall   = 1'b0;
  logic [7:0] prev_data    = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (bus.tx_valid !== 1'b1 || bus.tx_data !== prev_data)) stab_err++;
      if (bus.tx_valid === 1'b1) valid_cycles++;
      if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) rx_q.push_back(bus.tx_data);
      if (frame_done === 1'b1) begin
        done_cnt++;
        rd_per_frame.push_back(rd_count);
        rd_count = 0;
      end
      prev_stall = (bus.tx_valid === 1'b1) && (bus.tx_ready !== 1'b1);
      prev_data  = bus.tx_data;
    end
  end

  task automatic clear_logs();
    rx_q.delete();
    rd_per_frame.delete();
    done_cnt     = 0;
    rd_count     = 0;
    valid_cycles = 0;
    stab_err     = 0;
    rd_empty_err = 0;
  endtask

  task automatic wait_done(input int n, input int budget, output bit expired);
    int left = budget;
    while (done_cnt < n && left > 0) begin
      @(posedge clk);
      left--;
    end
    expired = (done_cnt < n);
    @(posedge clk);
    #1;
  endtask

  function automatic bq_t build_frame(bq_t pl);
    bq_t        f;
    logic [7:0] x = 8'hA5;
    f.push_back(8'hA5);
    foreach (pl[i]) begin
      f.push_back(pl[i]);
      x ^= pl[i];
    end
    f.push_back(8'(pl.size()));
    x ^= 8'(pl.size());
    f.push_back(x);
    return f;
  endfunction

  task automatic test_reset();
    bus.tx_ready = 1'b0;
    enable       = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b exp 0", bus.tx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
    checks++; if (bus.fifo_rd_ins !== 1'b0) begin errors++; $display("FAIL reset_rd_ins got %b exp 0", bus.fifo_rd_ins); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h exp 00", bus.tx_data); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_timeout_frame();
    bq_t exp = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h03, 8'hA6};
    int  k   = 0;
    bit  to;
    clear_logs();
    bus.tx_ready = 1'b1;
    enable       = 1'b1;
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    fifo_q.push_back(8'h33);
    while (busy !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++; if (k !== 18) begin errors++; $display("FAIL t1_start_latency got %0d exp 18", k); end
    wait_done(1, 200, to);
    checks++; if (to) begin errors++; $display("FAIL t1_timeout got done=%0d exp 1", done_cnt); end
    checks++; if (rx_q.size() !== exp.size()) begin errors++; $display("FAIL t1_len got %0d exp %0d", rx_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp[i]) begin errors++; $display("FAIL t1_byte%0d got %h exp %h", i, rx_q[i], exp[i]); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL t1_done_cnt got %0d exp 1", done_cnt); end
    checks++; if (rd_per_frame.size() != 1 || rd_per_frame[0] !== 3) begin errors++; $display("FAIL t1_reads got %0d exp 3", rd_count); end
  endtask

  task automatic test_limit_frame();
    bq_t exp;
    int  k = 0;
    bit  to;
    clear_logs();
    exp.push_back(8'hA5);
    for (int i = 0; i < 58; i++) begin
      fifo_q.push_back(8'(i));
      exp.push_back(8'(i));
    end
    exp.push_back(8'h3A);
    exp.push_back(8'h9E);
    while (busy !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++; if (k !== 3) begin errors++; $display("FAIL t2_start_latency got %0d exp 3", k); end
    wait_done(1, 500, to);
    checks++; if (to) begin errors++; $display("FAIL t2_timeout got done=%0d exp 1", done_cnt); end
    checks++; if (rx_q.size() !== exp.size()) begin errors++; $display("FAIL t2_len got %0d exp %0d", rx_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp[i]) begin errors++; $display("FAIL t2_byte%0d got %h exp %h", i, rx_q[i], exp[i]); end
    end
    checks++; if (fifo_q.size() !== 0) begin errors++; $display("FAIL t2_fifo_left got %0d exp 0", fifo_q.size()); end
    checks++; if (rd_empty_err !== 0) begin errors++; $display("FAIL t2_rd_empty got %0d exp 0", rd_empty_err); end
  endtask

  task automatic test_two_frames();
    bq_t pl1;
    bq_t pl2;
    bq_t exp;
    bq_t f2;
    bit  to;
    clear_logs();
    for (int i = 0; i < 70; i++) begin
      fifo_q.push_back(8'(8'h40 + i));
      if (i < 58) pl1.push_back(8'(8'h40 + i));
      else        pl2.push_back(8'(8'h40 + i));
    end
    exp = build_frame(pl1);
    f2  = build_frame(pl2);
    foreach (f2[i]) exp.push_back(f2[i]);
    wait_done(2, 1500, to);
    checks++; if (to) begin errors++; $display("FAIL t3_timeout got done=%0d exp 2", done_cnt); end
    checks++; if (exp[59] !== 8'h3A || exp[60] !== 8'h9E) begin errors++; $display("FAIL t3_model_trailer got %h %h exp 3a 9e", exp[59], exp[60]); end
    checks++; if (rx_q.size() !== exp.size()) begin errors++; $display("FAIL t3_len got %0d exp %0d", rx_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp[i]) begin errors++; $display("FAIL t3_byte%0d got %h exp %h", i, rx_q[i], exp[i]); end
    end
    checks++; if (rx_q.size() > 74 && rx_q[74] !== 8'h0C) begin errors++; $display("FAIL t3_len2 got %h exp 0c", rx_q[74]); end
    checks++; if (rd_per_frame.size() != 2) begin errors++; $display("FAIL t3_frames got %0d exp 2", rd_per_frame.size()); end
    else begin
      checks++; if (rd_per_frame[0] !== 58) begin errors++; $display("FAIL t3_reads1 got %0d exp 58", rd_per_frame[0]); end
      checks++; if (rd_per_frame[1] !== 12) begin errors++; $display("FAIL t3_reads2 got %0d exp 12", rd_per_frame[1]); end
    end
  endtask

  task automatic test_backpressure();
    bq_t exp  = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h03, 8'hA6};
    int  left = 1000;
    clear_logs();
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    fifo_q.push_back(8'h33);
    while (done_cnt < 1 && left > 0) begin
      @(posedge clk); #1;
      bus.tx_ready = 1'($urandom_range(0, 1));
      left--;
    end
    bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL t4_done got %0d exp 1", done_cnt); end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL t4_stable got %0d exp 0", stab_err); end
    checks++; if (rx_q.size() !== exp.size()) begin errors++; $display("FAIL t4_len got %0d exp %0d", rx_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp[i]) begin errors++; $display("FAIL t4_byte%0d got %h exp %h", i, rx_q[i], exp[i]); end
    end
    checks++; if (rd_per_frame.size() != 1 || rd_per_frame[0] !== 3) begin errors++; $display("FAIL t4_reads got %0d exp 3", rd_count); end
  endtask

  task automatic test_reset_mid_frame();
    bq_t exp  = '{8'hA5, 8'h33, 8'h01, 8'h97};
    int  left = 200;
    bit  to;
    clear_logs();
    bus.tx_ready = 1'b1;
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    fifo_q.push_back(8'h33);
    while (!(bus.tx_valid === 1'b1 && bus.tx_data === 8'h22) && left > 0) begin
      @(negedge clk);
      left--;
    end
    checks++; if (left == 0) begin errors++; $display("FAIL t5_reach_payload2 got timeout exp tx_data 22"); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL t5_valid got %b exp 0", bus.tx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_busy got %b exp 0", busy); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL t5_data got %h exp 00", bus.tx_data); end
    checks++; if (bus.fifo_rd_ins !== 1'b0) begin errors++; $display("FAIL t5_rd got %b exp 0", bus.fifo_rd_ins); end
    checks++; if (fifo_q.size() !== 1) begin errors++; $display("FAIL t5_fifo_left got %0d exp 1", fifo_q.size()); end
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_idle_after got %b exp 0", busy); end
    wait_done(1, 200, to);
    checks++; if (to) begin errors++; $display("FAIL t5_timeout got done=%0d exp 1", done_cnt); end
    checks++; if (rx_q.size() !== exp.size()) begin errors++; $display("FAIL t5_len got %0d exp %0d", rx_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp[i]) begin errors++; $display("FAIL t5_byte%0d got %h exp %h", i, rx_q[i], exp[i]); end
    end
  endtask

  task automatic test_enable();
    bq_t exp;
    int  left = 20;
    bit  to;
    clear_logs();
    enable = 1'b0;
    exp.push_back(8'hA5);
    for (int i = 0; i < 58; i++) begin
      fifo_q.push_back(8'(i));
      exp.push_back(8'(i));
    end
    exp.push_back(8'h3A);
    exp.push_back(8'h9E);
    repeat (40) @(negedge clk);
    checks++; if (valid_cycles !== 0) begin errors++; $display("FAIL t6_no_valid got %0d exp 0", valid_cycles); end
    checks++; if (rd_count !== 0) begin errors++; $display("FAIL t6_no_reads got %0d exp 0", rd_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_idle got %b exp 0", busy); end
    enable = 1'b1;
    while (busy !== 1'b1 && left > 0) begin
      @(negedge clk);
      left--;
    end
    repeat (10) @(posedge clk);
    #1;
    enable = 1'b0;
    wait_done(1, 500, to);
    checks++; if (to) begin errors++; $display("FAIL t6_timeout got done=%0d exp 1", done_cnt); end
    checks++; if (rx_q.size() !== exp.size()) begin errors++; $display("FAIL t6_len got %0d exp %0d", rx_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp[i]) begin errors++; $display("FAIL t6_byte%0d got %h exp %h", i, rx_q[i], exp[i]); end
    end
    repeat (30) @(posedge clk);
    #1;
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL t6_done_cnt got %0d exp 1", done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_busy_end got %b exp 0", busy); end
    checks++; if (rd_empty_err !== 0) begin errors++; $display("FAIL t6_rd_empty got %0d exp 0", rd_empty_err); end
  endtask

  initial begin
    test_reset();
    test_timeout_frame();
    test_limit_frame();
    test_two_frames();
    test_backpressure();
    test_reset_mid_frame();
    test_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got time limit exp all tests complete");
    $fatal(1, "watchdog");
  end

endmodule
